// File: rtl/quota_pkg.sv
// Shared types and helpers for the quota bitstream converter.
package quota_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1
  } state_e;

  typedef enum logic {
    UNARY  = 1'b0,
    SPREAD = 1'b1
  } mode_e;

  localparam int unsigned BR_MAX = 32'd16;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BR_MAX-1:0] bitrev(input logic [BR_MAX-1:0] v, input int unsigned w);
    logic [BR_MAX-1:0] r;
    r = {<<{v}};
    return r >> (BR_MAX - w);
  endfunction

endpackage

// File: rtl/quota_calc.sv
// Converts one signed sample to a ones-count quota in 0..BITSTREAM.
module quota_calc #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8
) (
  input  logic signed [QUANT-1:0]          data,
  output logic        [$clog2(BITSTREAM):0] quota
);

  localparam int LB = $clog2(BITSTREAM);
  localparam int QW = LB + 32'sd1;
  localparam int D  = QUANT - LB;

  localparam logic [QUANT:0]  BIAS = {{QUANT{1'b0}}, 1'b1} << (QUANT - 32'sd1);
  localparam logic [QW-1:0]   QMAX = QW'(BITSTREAM);

  logic [QUANT:0]  biased_s;
  logic [QUANT:0]  rounded_s;
  logic [QW-1:0]   shifted_s;

  // One guard bit above the sample keeps +max from wrapping after bias and rounding.
  assign biased_s = {data[QUANT-1], data} + BIAS;

  if (D > 32'sd0) begin : g_round
    localparam logic [QUANT:0] RND = {{QUANT{1'b0}}, 1'b1} << (D - 32'sd1);
    assign rounded_s = biased_s + RND;
  end else begin : g_no_round
    assign rounded_s = biased_s;
  end

  assign shifted_s = QW'(rounded_s >> D);
  assign quota     = (shifted_s > QMAX) ? QMAX : shifted_s;

endmodule

// File: rtl/quota_stream.sv
// Multi-channel quota converter emitting unary or bit-reversed stochastic bitstreams.
module quota_stream
  import quota_pkg::*;
#(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8,
  parameter int CH        = 4,
  parameter int QW        = $clog2(BITSTREAM) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*QUANT-1:0] in_data,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH-1:0]       out_bits,
  output logic                out_last,
  output logic [CH*QW-1:0]    quota_out
);

  localparam int LB = $clog2(BITSTREAM);
  localparam logic [LB-1:0] CNT_LAST = LB'(BITSTREAM - 32'sd1);
  localparam logic [LB-1:0] CNT_ONE  = {{(LB-1){1'b0}}, 1'b1};

  if ((BITSTREAM & (BITSTREAM - 32'sd1)) != 32'sd0) begin : g_chk_pow2
    $error("quota_stream: BITSTREAM must be a power of 2");
  end
  if (QUANT < LB) begin : g_chk_quant
    $error("quota_stream: QUANT must be at least clog2(BITSTREAM)");
  end

  state_e        state_r, state_nxt_s;
  mode_e         mode_r;
  logic [LB-1:0] cnt_r, cnt_nxt_s, idx_s;
  logic [QW-1:0] q_r      [CH];
  logic [QW-1:0] q_calc_s [CH];
  logic          load_s, last_s;

  for (genvar c = 0; c < CH; c++) begin : g_calc
    quota_calc #(
      .BITSTREAM (BITSTREAM),
      .QUANT     (QUANT)
    ) u_calc (
      .data  (in_data[c*QUANT +: QUANT]),
      .quota (q_calc_s[c])
    );
  end

  assign last_s   = (state_r == STREAM) && (cnt_r == CNT_LAST);
  // Combinational out_ready -> in_ready lets a new vector load on the last beat with no bubble.
  assign in_ready = (state_r == IDLE) || (last_s && out_ready);

  // Next-state, beat counter and capture decision.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = STREAM;
          cnt_nxt_s   = '0;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last_s) begin
            cnt_nxt_s = '0;
            if (in_valid) begin
              state_nxt_s = STREAM;
              load_s      = 1'b1;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, counter and captured quota/mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      mode_r  <= UNARY;
      for (int c = 0; c < CH; c++) begin
        q_r[c] <= '0;
      end
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (load_s) begin
        mode_r <= mode_e'(in_mode);
        for (int c = 0; c < CH; c++) begin
          q_r[c] <= q_calc_s[c];
        end
      end else begin
        mode_r <= mode_r;
      end
    end
  end

  // Bit decode: a stream bit is high while the (possibly reversed) beat index is below the quota.
  always_comb begin
    out_bits  = '0;
    quota_out = '0;
    if (mode_r == SPREAD) begin
      idx_s = LB'(bitrev(BR_MAX'(cnt_r), LB));
    end else begin
      idx_s = cnt_r;
    end
    for (int c = 0; c < CH; c++) begin
      out_bits[c]            = (state_r == STREAM) && ({1'b0, idx_s} < q_r[c]);
      quota_out[c*QW +: QW] = q_r[c];
    end
    out_valid = (state_r == STREAM);
    out_last  = last_s;
  end

endmodule

// File: tb/tb_quota_stream.sv
// Directed plus randomised bench for quota_stream against an arithmetic reference model.
module tb_quota_stream;

  localparam int BITSTREAM = 64;
  localparam int QUANT     = 8;
  localparam int CH        = 4;
  localparam int LB        = $clog2(BITSTREAM);
  localparam int QW        = LB + 1;
  localparam int D         = QUANT - LB;

  logic                clk = 1'b0;
  logic                rst_n, in_valid, in_ready, in_mode;
  logic                out_valid, out_ready, out_last;
  logic [CH*QUANT-1:0] in_data;
  logic [CH-1:0]       out_bits;
  logic [CH*QW-1:0]    quota_out;

  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_q [CH];
  logic exp_mode;

  always #5 clk = ~clk;

  quota_stream #(.BITSTREAM(BITSTREAM), .QUANT(QUANT), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_bits(out_bits), .out_last(out_last),
    .quota_out(quota_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int ref_quota(input logic [QUANT-1:0] raw);
    int b, r, q;
    b = int'($signed(raw)) + (1 << (QUANT - 1));
    r = (D > 0) ? b + (1 << (D - 1)) : b;
    q = r >> D;
    if (q > BITSTREAM) q = BITSTREAM;
    return q;
  endfunction

  function automatic int ref_rev(input int k);
    int r = 0;
    for (int i = 0; i < LB; i++) if ((k >> i) & 1) r = r | (1 << (LB - 1 - i));
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_bits(input int k);
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = ((exp_mode ? ref_rev(k) : k) < exp_q[c]);
    return v;
  endfunction

  function automatic logic [CH*QW-1:0] exp_quota_vec();
    logic [CH*QW-1:0] v;
    for (int c = 0; c < CH; c++) v[c*QW +: QW] = QW'(exp_q[c]);
    return v;
  endfunction

  task automatic set_expected(input logic [CH*QUANT-1:0] d, input logic m);
    for (int c = 0; c < CH; c++) exp_q[c] = ref_quota(d[c*QUANT +: QUANT]);
    exp_mode = m;
  endtask

  // Called just after a falling edge with the block idle; returns on the falling edge after capture.
  task automatic start_vec(input logic [CH*QUANT-1:0] d, input logic m);
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    out_ready = 1'($urandom);
    #1;
    chk("in_ready_idle", in_ready, 1);
    chk("out_valid_idle", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_mode  = 1'($urandom);
    set_expected(d, m);
    @(negedge clk);
  endtask

  task automatic stream_beats(input int stall_pct, input int stop_at, input bit chain,
                              input logic [CH*QUANT-1:0] nd, input logic nm);
    int k = 0;
    int cyc = 0;
    int pop [CH];
    for (int c = 0; c < CH; c++) pop[c] = 0;
    while (k < stop_at && cyc < 4000) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      if (chain && k == BITSTREAM - 1) begin
        in_valid = 1'b1;
        in_data  = nd;
        in_mode  = nm;
      end
      #1;
      chk("out_valid", out_valid, 1);
      chk("out_last", out_last, k == BITSTREAM - 1);
      chk("out_bits", out_bits, exp_bits(k));
      chk("quota_out", quota_out, exp_quota_vec());
      chk("in_ready_stream", in_ready, (k == BITSTREAM - 1) && out_ready);
      if (out_ready) begin
        for (int c = 0; c < CH; c++) pop[c] += int'(out_bits[c]);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("beats_done", k, stop_at);
    if (stop_at == BITSTREAM) begin
      for (int c = 0; c < CH; c++) chk("popcount", pop[c], exp_q[c]);
    end
  endtask

  task automatic idle_check();
    #1;
    chk("out_valid_after", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
    chk("out_last_after", out_last, 0);
  endtask

  initial begin
    logic [CH*QUANT-1:0] d, nd;
    logic m, nm;
    bit   chain;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    exp_mode  = 1'b0;
    for (int c = 0; c < CH; c++) exp_q[c] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_quota_out", quota_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check();

    // Directed: {-128,-1,0,2} unary, then +127 everywhere, then spread quotas {32,1,64,31}.
    start_vec(32'h0200FF80, 1'b0);
    chk("quota_dir_ch3", exp_q[3], 33);
    stream_beats(0, BITSTREAM, 1'b0, '0, 1'b0);
    idle_check();
    start_vec(32'h7F7F7F7F, 1'b0);
    stream_beats(0, BITSTREAM, 1'b0, '0, 1'b0);
    idle_check();
    start_vec(32'hFD7F8200, 1'b1);
    stream_beats(0, BITSTREAM, 1'b0, '0, 1'b0);
    idle_check();

    // Same vectors under 50% output stalls.
    start_vec(32'h0200FF80, 1'b0);
    stream_beats(50, BITSTREAM, 1'b0, '0, 1'b0);
    idle_check();
    start_vec(32'hFD7F8200, 1'b1);
    stream_beats(50, BITSTREAM, 1'b0, '0, 1'b0);
    idle_check();

    // Back-to-back: second vector loads on the first stream's last beat.
    start_vec(32'h0200FF80, 1'b0);
    stream_beats(0, BITSTREAM, 1'b1, 32'hFD7F8200, 1'b1);
    in_valid = 1'b0;
    in_data  = $urandom;
    set_expected(32'hFD7F8200, 1'b1);
    stream_beats(0, BITSTREAM, 1'b0, '0, 1'b0);
    idle_check();

    // Random vectors, modes, stalls and chaining.
    d = $urandom;
    m = 1'($urandom);
    start_vec(d, m);
    for (int i = 0; i < 6; i++) begin
      chain = (i < 5) && ($urandom_range(1) == 1);
      nd    = $urandom;
      nm    = 1'($urandom);
      stream_beats((i % 2 == 1) ? 50 : 0, BITSTREAM, chain, nd, nm);
      if (chain) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        set_expected(nd, nm);
      end else begin
        idle_check();
        if (i < 5) start_vec(nd, nm);
      end
    end

    // Reset mid-stream at beat 20, with a vector offered during reset.
    start_vec(32'h7F7F7F7F, 1'b1);
    stream_beats(0, 20, 1'b0, '0, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h01020304;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_bits", out_bits, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_quota_out", quota_out, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_no_capture", out_valid, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle_check();
    start_vec(32'h0200FF80, 1'b1);
    stream_beats(0, BITSTREAM, 1'b0, '0, 1'b0);
    idle_check();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/quota_stream.md
Name: quota_stream

Overview:
Multi-channel successor to the single-channel quota converter. It accepts a vector of CH signed QUANT-bit values and converts each value to a quota, which is a ones-count in the range 0..BITSTREAM. It then emits, one bit per channel per accepted beat, a BITSTREAM-long stochastic bitstream whose popcount equals that quota. Two encodings are provided: unary (thermometer) and bit-reversed spread. The block sits between the quantised activation/weight source and the bitstream MAC array.

Parameters:
BITSTREAM, 64, stream length in bits; must be a power of 2 (elaboration $error otherwise).
QUANT, 8, input data width; must satisfy QUANT >= $clog2(BITSTREAM) (elaboration $error otherwise).
CH, 4, number of parallel channels.
QW, $clog2(BITSTREAM)+1, derived quota width; holds 0..BITSTREAM inclusive.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input vector valid.
in_ready  out  1  block can accept a vector.
in_data  in  CH*QUANT  signed two's-complement values; channel c occupies [c*QUANT +: QUANT].
in_mode  in  1  encoding, captured with in_data: 0 = UNARY, 1 = SPREAD.
out_valid  out  1  out_bits is valid.
out_ready  in  1  downstream accepts the current bit beat.
out_bits  out  CH  current stream bit, one per channel.
out_last  out  1  marks the final beat (beat index BITSTREAM-1) of a stream.
quota_out  out  CH*QW  registered quotas of the stream in progress.

Behaviour:
- Quota arithmetic, per channel, with D = QUANT - $clog2(BITSTREAM):
  - Bias: b = data + 2^(QUANT-1), computed in QUANT+1 bits.
  - Rounding: if D>0, r = b + 2^(D-1); if D==0, r = b.
  - Quota: q = r >> D, taken at QW bits, never truncated to $clog2(BITSTREAM) bits.
  - The maximum is exactly BITSTREAM for D>0 (data=+max); it must not wrap to 0.
  - Result is clamped to BITSTREAM.
- States: IDLE, STREAM (2-bit enum). Registers: state, beat counter cnt ($clog2(BITSTREAM) bits), q[CH], mode.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch q[] and mode, set cnt=0, go to STREAM.
- STREAM:
  - out_valid=1.
  - UNARY: out_bits[c] = (cnt < q[c]).
  - SPREAD: out_bits[c] = (bitrev(cnt) < q[c]), where bitrev reverses the $clog2(BITSTREAM) bits.
  - Both encodings emit exactly q[c] ones per stream.
  - out_last = (cnt == BITSTREAM-1).
  - On out_valid&&out_ready: cnt increments.
- Last beat:
  - On the last beat handshake, the block returns to IDLE.
  - If in_valid is high in the same cycle, it instead reloads q/mode, sets cnt=0 and stays in STREAM. There is no bubble.
  - in_ready = IDLE || (STREAM && out_last && out_ready). This is a documented combinational path from out_ready to in_ready.
- Stall: while out_ready=0, cnt, out_bits, out_last and quota_out hold stable. out_valid is never withdrawn mid-stream.
- Throughput: BITSTREAM cycles per vector under continuous out_ready.
- Reset:
  - rst_n low at any time, including mid-stream, forces state=IDLE, cnt=0, q=0, mode=0 immediately.
  - While reset: out_valid=0, out_bits=0, out_last=0, quota_out=0.
  - No transfer is captured while rst_n is low. The partial stream is discarded; there is no resume.
- Mode changes only take effect at capture. in_mode is ignored when not accepting.

Decomposition:
- quota_pkg holds:
  - mode_e enum (UNARY, SPREAD) and state_e enum (IDLE, STREAM).
  - function bitrev(): reverses $clog2(BITSTREAM) bits.
- Sub-module quota_calc: combinational, parameters BITSTREAM/QUANT, signed data in, QW-bit quota out. The top instantiates it CH times in a generate loop.

Test Plan:
- Defaults (D=2), UNARY, data {-128, -1, 0, 2}: quota_out = {0, 32, 32, 33}. Channel 3 emits 33 ones followed by 31 zeros; channel 0 emits all zeros. out_last is asserted on beat 63 only.
- data=+127 on all channels: quota=64, not 0. Every beat emits 1s. data=-3 gives quota 31.
- SPREAD, quota 32: pattern 1,0,1,0… over 64 beats. Quota 1: only beat 0 is high. Quota 64: all beats high. Popcount per channel equals quota.
- Random out_ready stalls (50% duty): bits are held during stalls, and the sequence is identical to the no-stall run. in_ready stays 0 until the last beat handshake.
- Back-to-back vectors with in_valid held high: the second stream's beat 0 follows the first stream's beat 63 in the next cycle, with no gap.
- Assert rst_n=0 at beat 20 for 1 cycle: outputs go to 0 asynchronously. After release the block is in IDLE with in_ready=1, and the next vector streams from beat 0.
